// File: rtl/div_iter_pkg.sv
// Shared multdiv definitions for the iterative signed divider: FSM states,
// sizing constants, overflow operands and the captured-operand record.
package div_iter_pkg;

  localparam int WIDTH     = 32;
  localparam int CNT_W     = 6;
  localparam int LAST_ITER = 31;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Operands as latched on the start edge; magnitudes are unsigned so
  // |INT_MIN| is representable.
  typedef struct packed {
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             sign_q;
    logic             sign_r;
    logic             ovf;
  } div_op_t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter_ctrl.sv
// Divider control: FSM plus iteration counter, sequencing load, one
// non-restoring step per RUN cycle, the sign fix-up and the ready pulse.
module div_ctrl
  import div_iter_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int LAST  = 31
) (
  input  logic clk,
  input  logic resetn,
  input  logic ctrl_div,
  input  logic divisor_zero,
  input  logic p_sign,
  output logic load,
  output logic iterate,
  output logic add_not_sub,
  output logic fix,
  output logic ready
);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // A start request wins in every state, abandoning whatever was in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = IDLE;
      RUN: begin
        if (divisor_zero)                  state_nxt = DONE;
        else if (count == CNT_W'(LAST))    state_nxt = FIX;
        else                               state_nxt = RUN;
      end
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ctrl_div) state_nxt = RUN;
  end

  always_comb begin
    load        = ctrl_div;
    iterate     = (state == RUN) && !divisor_zero;
    add_not_sub = p_sign;
    // Divide-by-zero writes its fixed outputs from the first RUN cycle.
    fix         = (state == FIX) || ((state == RUN) && divisor_zero);
    ready       = (state == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      count <= '0;
    else if (load)    count <= '0;
    else if (iterate) count <= count + 1'b1;
  end

endmodule

// File: rtl/div_iter.sv
// Sequential signed divider: non-restoring radix-2 on operand magnitudes,
// one quotient bit per cycle, then sign correction into output registers.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  div_op_t          op_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic             divisor_zero;
  logic             load, iterate, add_not_sub, fix;
  logic [WIDTH:0]   alu_a, alu_b, alu_y;
  logic [WIDTH-1:0] rem_mag;

  div_ctrl #(.CNT_W(CNT_W), .LAST(WIDTH-1)) u_ctrl (
    .clk          (clk),
    .resetn       (resetn),
    .ctrl_div     (ctrl_div),
    .divisor_zero (divisor_zero),
    .p_sign       (p_q[WIDTH]),
    .load         (load),
    .iterate      (iterate),
    .add_not_sub  (add_not_sub),
    .fix          (fix),
    .ready        (data_resultRDY)
  );

  assign divisor_zero = (op_q.b_mag == '0);

  // One shared 33-bit adder: shifted {P,Q} while iterating, plain P for the
  // final remainder restore.
  assign alu_a   = iterate ? {p_q[WIDTH-1:0], q_q[WIDTH-1]} : p_q;
  assign alu_b   = {1'b0, op_q.b_mag};
  assign alu_y   = add_not_sub ? (alu_a + alu_b) : (alu_a - alu_b);
  assign rem_mag = p_q[WIDTH] ? alu_y[WIDTH-1:0] : p_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q <= '0;
      p_q  <= '0;
      q_q  <= '0;
    end else if (load) begin
      op_q.a_mag  <= mag(data_operandA);
      op_q.b_mag  <= mag(data_operandB);
      op_q.sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      op_q.sign_r <= data_operandA[WIDTH-1];
      op_q.ovf    <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
      p_q         <= '0;
      q_q         <= mag(data_operandA);
    end else if (iterate) begin
      p_q <= alu_y;
      q_q <= {q_q[WIDTH-2:0], ~alu_y[WIDTH]};
    end
  end

  // Outputs hold between operations; only a new start clears the exception.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (load) begin
      data_exception <= 1'b0;
    end else if (fix) begin
      if (divisor_zero) begin
        data_result    <= '0;
        data_remainder <= op_q.sign_r ? -op_q.a_mag : op_q.a_mag;
        data_exception <= 1'b1;
      end else begin
        data_result    <= op_q.sign_q ? -q_q : q_q;
        data_remainder <= op_q.sign_r ? -rem_mag : rem_mag;
        data_exception <= op_q.ovf;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized issue
// (including restarts) against a cycle-level arithmetic model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result, data_remainder;
  logic        data_exception, data_resultRDY;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  div_iter dut (
    .clk            (clk),
    .resetn         (resetn),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } res_t;

  function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b);
    res_t   o;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      o.q = 32'd0; o.r = a; o.e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      o.q = 32'h8000_0000; o.r = 32'd0; o.e = 1'b1;
    end else begin
      o.q = 32'(sa / sb); o.r = 32'(sa % sb); o.e = 1'b0;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: result lands 33 edges after capture (1 for a zero divisor); a new
  // capture abandons the pending one; outputs hold between results.
  longint      cyc = 0, due = 0;
  bit          pend = 1'b0;
  res_t        p_exp = '0;
  logic [31:0] m_res = '0, m_rem = '0;
  logic        m_exc = 1'b0, m_rdy = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc <= 0; pend <= 1'b0; m_res <= '0; m_rem <= '0; m_exc <= 1'b0; m_rdy <= 1'b0;
    end else begin
      cyc   <= cyc + 1;
      m_rdy <= 1'b0;
      if (ctrl_div) begin
        pend  <= 1'b1;
        due   <= cyc + ((data_operandB == 32'd0) ? 1 : 33);
        p_exp <= ref_div(data_operandA, data_operandB);
        m_exc <= 1'b0;
      end else if (pend && cyc == due) begin
        pend  <= 1'b0;
        m_rdy <= 1'b1;
        m_res <= p_exp.q;
        m_rem <= p_exp.r;
        m_exc <= p_exp.e;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_rdy", 32'(data_resultRDY), 32'(m_rdy));
      chk("mon_result", data_result, m_res);
      chk("mon_remainder", data_remainder, m_rem);
      chk("mon_exception", 32'(data_exception), 32'(m_exc));
    end
  end

  // Callers sit at a negedge; capture happens on the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    ctrl_div = 1'b1; data_operandA = a; data_operandB = b;
    @(negedge clk);
    ctrl_div = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
  endtask

  // Negedges from the one after capture until ready is seen; -1 on timeout.
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!data_resultRDY && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!data_resultRDY) lat = -1;
  endtask

  task automatic run_directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input int exp_lat, input logic [31:0] eq,
                              input logic [31:0] er, input logic ee);
    int lat;
    issue(a, b);
    wait_rdy(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_q"}, data_result, eq);
    chk({nm, "_r"}, data_remainder, er);
    chk({nm, "_e"}, 32'(data_exception), 32'(ee));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'($signed($urandom_range(0, 40)) - 20);
      1: return 32'd0;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(1, 1000));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    res_t m;
    int   lat, pulses, gap;

    // Pin the model with hand-computed values.
    m = ref_div(32'd100, 32'd7);
    chk("model_100_7_q", m.q, 32'd14);
    chk("model_100_7_r", m.r, 32'd2);
    m = ref_div(32'hFFFF_FF9C, 32'd7);
    chk("model_m100_7_q", m.q, 32'hFFFF_FFF2);
    chk("model_m100_7_r", m.r, 32'hFFFF_FFFE);
    m = ref_div(32'd100, 32'hFFFF_FFF9);
    chk("model_100_m7_q", m.q, 32'hFFFF_FFF2);
    chk("model_100_m7_r", m.r, 32'd2);
    m = ref_div(32'h8000_0000, 32'd1);
    chk("model_min_1_q", m.q, 32'h8000_0000);
    chk("model_min_1_e", 32'(m.e), 32'd0);

    repeat (3) @(negedge clk);
    chk("reset_result", data_result, 32'd0);
    chk("reset_remainder", data_remainder, 32'd0);
    chk("reset_exception", 32'(data_exception), 32'd0);
    chk("reset_rdy", 32'(data_resultRDY), 32'd0);
    resetn = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    run_directed("d100_7", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    run_directed("dm100_7", 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_directed("d100_m7", 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_directed("d5_0", 32'd5, 32'd0, 1, 32'd0, 32'd5, 1'b1);
    // Issued while ready is still high: capture on the pulse's closing edge.
    issue(32'd8, 32'd2);
    chk("exc_cleared", 32'(data_exception), 32'd0);
    wait_rdy(lat);
    chk("d8_2_lat", 32'(lat), 32'd33);
    chk("d8_2_q", data_result, 32'd4);
    chk("d8_2_e", 32'(data_exception), 32'd0);
    run_directed("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b1);
    run_directed("min_1", 32'h8000_0000, 32'd1, 33, 32'h8000_0000, 32'd0, 1'b0);

    // Restart at E10 of 1000/3 with 9/4.
    issue(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    run_directed("restart", 32'd9, 32'd4, 33, 32'd2, 32'd1, 1'b0);

    // Reset at E15 of 77/5.
    issue(32'd77, 32'd5);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_result", data_result, 32'd0);
    chk("midrst_remainder", data_remainder, 32'd0);
    chk("midrst_exception", 32'(data_exception), 32'd0);
    chk("midrst_rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (data_resultRDY) pulses++;
    end
    chk("midrst_no_pulse", 32'(pulses), 32'd0);
    run_directed("d77_5", 32'd77, 32'd5, 33, 32'd15, 32'd2, 1'b0);

    // Random issue with random gaps; short gaps exercise restarts.
    for (int n = 0; n < 200; n++) begin
      issue(pick(), pick());
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(30, 40);
      repeat (gap) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
